// File: rtl/shared_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shared_sram_pkg
// Description : Shared types and helpers for the shared SRAM responder.
//               state_t    : responder FSM states
//               req_kind_t : latched request kind (read / write)
//               wait_w()   : access-counter width for a given cycle count
// Revision    : 1.0 - initial release
// ============================================================================
package shared_sram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } req_kind_t;

  // Port index width; grant_id is fixed at 2 bits (up to 4 cores).
  localparam int PORT_W = 2;

  // Smallest width (at least 1) able to count 0 .. cycles-1.
  function automatic int wait_w(input int cycles);
    int w;
    w = 1;
    while ((1 << w) < cycles) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shared_sram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : shared_sram_responder_if
// Description : Core-side memory bus shared by all requesting cores.
//               CE/OE/WE/UB/LB : per-port active-low strobes (core -> resp)
//               ADDR           : packed per-port address, port 0 in LSBs
//               Data_to_SRAM   : packed per-port write data
//               memReady       : one-hot completion pulse (resp -> core)
//               Data_from_SRAM : read data, valid with any memReady bit
// Revision    : 1.0 - initial release
// ============================================================================
interface shared_sram_responder_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = 16
);

  logic [NUM_PORTS-1:0]        CE;
  logic [NUM_PORTS-1:0]        OE;
  logic [NUM_PORTS-1:0]        WE;
  logic [NUM_PORTS-1:0]        UB;
  logic [NUM_PORTS-1:0]        LB;
  logic [NUM_PORTS*ADDR_W-1:0] ADDR;
  logic [NUM_PORTS*DATA_W-1:0] Data_to_SRAM;
  logic [NUM_PORTS-1:0]        memReady;
  logic [DATA_W-1:0]           Data_from_SRAM;

  // Core side
  modport master (
    output CE, OE, WE, UB, LB, ADDR, Data_to_SRAM,
    input  memReady, Data_from_SRAM
  );

  // Responder side
  modport slave (
    input  CE, OE, WE, UB, LB, ADDR, Data_to_SRAM,
    output memReady, Data_from_SRAM
  );

endinterface
`default_nettype wire

// File: rtl/shared_sram_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin selector. Picks the first asserted
//               request at or after ptr, wrapping modulo NUM_PORTS.
//               req       : request vector
//               ptr       : starting port (must be < NUM_PORTS)
//               grant     : one-hot grant
//               grant_idx : index of granted port
//               valid     : any request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import shared_sram_pkg::*;
#(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PORT_W'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : shared_sram_responder
// Description : Memory-side responder serving NUM_PORTS cores on a single
//               external async SRAM. Round-robin arbitration, fixed-length
//               SRAM access, one-cycle memReady pulse, then waits for the
//               served core to release CE before accepting new work.
// Ports       : Clk            - system clock, rising edge
//               Reset          - asynchronous, active-low
//               bus            - core-side bus (slave modport)
//               grant_id       - port currently / last served
//               busy           - high from grant until release
//               SRAM_ADDR      - chip address
//               SRAM_*_N       - chip strobes, active-low
//               SRAM_DQ        - chip data, driven only during write access
// Revision    : 1.0 - initial release
// ============================================================================
module shared_sram_responder
  import shared_sram_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  shared_sram_responder_if.slave   bus,
  output logic [PORT_W-1:0]        grant_id,
  output logic                     busy,
  output logic [ADDR_W-1:0]        SRAM_ADDR,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N,
  inout  wire  [DATA_W-1:0]        SRAM_DQ
);

  localparam int                 c_CNT_W = wait_w(WAIT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WAIT_CYCLES - 1);
  localparam logic [PORT_W-1:0]  c_MAXP  = PORT_W'(NUM_PORTS - 1);

  state_t               r_state;
  state_t               w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [PORT_W-1:0]    r_grant;
  logic [PORT_W-1:0]    r_ptr;
  req_kind_t            r_kind;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_ub_n;
  logic                 r_lb_n;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_busy;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_gnt_oh;
  logic [PORT_W-1:0]    w_gnt_idx;
  logic                 w_gnt_valid;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_data;
  logic                 w_sel_we_n;
  logic                 w_sel_ub_n;
  logic                 w_sel_lb_n;
  logic                 w_ce_grant;
  logic                 w_last;
  logic                 w_dq_oe;

  // --------------------------------------------------------------------------
  // Request decode: chip enable plus either read or write strobe.
  // --------------------------------------------------------------------------
  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
      assign w_req[p] = ~bus.CE[p] & (~bus.OE[p] | ~bus.WE[p]);
    end
  endgenerate

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .req       (w_req),
    .ptr       (r_ptr),
    .grant     (w_gnt_oh),
    .grant_idx (w_gnt_idx),
    .valid     (w_gnt_valid)
  );

  // Fields of the winning port, captured only at grant.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_we_n = 1'b1;
    w_sel_ub_n = 1'b1;
    w_sel_lb_n = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_gnt_oh[p]) begin
        w_sel_addr = bus.ADDR[p*ADDR_W +: ADDR_W];
        w_sel_data = bus.Data_to_SRAM[p*DATA_W +: DATA_W];
        w_sel_we_n = bus.WE[p];
        w_sel_ub_n = bus.UB[p];
        w_sel_lb_n = bus.LB[p];
      end
    end
  end

  // Live CE of the served port, used to detect release.
  always_comb begin
    w_ce_grant = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (r_grant == PORT_W'(p)) begin
        w_ce_grant = bus.CE[p];
      end
    end
  end

  assign w_last = (r_cnt == c_LAST);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_next = ACCESS;
      ACCESS:  if (w_last)      w_next = DONE;
      DONE:                     w_next = RELEASE;
      RELEASE: if (w_ce_grant)  w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_kind  <= RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_rdata <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_grant <= w_gnt_idx;
            r_kind  <= w_sel_we_n ? RD : WR;  // WE wins when both low
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_data;
            r_ub_n  <= w_sel_ub_n;
            r_lb_n  <= w_sel_lb_n;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ACCESS: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_kind == RD) begin
              r_rdata <= SRAM_DQ;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_ptr <= (r_grant == c_MAXP) ? '0 : r_grant + 2'd1;
        end
        RELEASE: begin
          if (w_ce_grant) begin
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // SRAM strobes and completion. Decoded straight from the async-reset state
  // so that reset releases the chip in the same cycle it is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    SRAM_CE_N    = 1'b1;
    SRAM_OE_N    = 1'b1;
    SRAM_WE_N    = 1'b1;
    SRAM_UB_N    = 1'b1;
    SRAM_LB_N    = 1'b1;
    w_dq_oe      = 1'b0;
    bus.memReady = '0;
    if (r_state == ACCESS) begin
      SRAM_CE_N = 1'b0;
      SRAM_UB_N = r_ub_n;
      SRAM_LB_N = r_lb_n;
      if (r_kind == WR) begin
        w_dq_oe   = 1'b1;
        // WE released on the final cycle while data is still driven (hold).
        SRAM_WE_N = w_last;
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
    if (r_state == DONE) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_grant == PORT_W'(p)) begin
          bus.memReady[p] = 1'b1;
        end
      end
    end
  end

  assign SRAM_DQ            = w_dq_oe ? r_wdata : {DATA_W{1'bz}};
  assign SRAM_ADDR          = r_addr;
  assign bus.Data_from_SRAM = r_rdata;
  assign grant_id           = r_grant;
  assign busy               = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shared_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_shared_sram_responder
// Description : Directed self-checking bench for shared_sram_responder with a
//               small behavioural SRAM model on the DQ bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_sram_responder;

  logic        Clk;
  logic        Reset;
  logic [1:0]  grant_id;
  logic        busy;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  wire  [15:0] sram_dq;

  int errors = 0;
  int checks = 0;

  shared_sram_responder_if #(.NUM_PORTS(4), .ADDR_W(20), .DATA_W(16)) bus ();

  shared_sram_responder #(
    .NUM_PORTS(4), .ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .SRAM_ADDR (sram_addr),
    .SRAM_CE_N (sram_ce_n),
    .SRAM_OE_N (sram_oe_n),
    .SRAM_WE_N (sram_we_n),
    .SRAM_UB_N (sram_ub_n),
    .SRAM_LB_N (sram_lb_n),
    .SRAM_DQ   (sram_dq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: 256 words, drives DQ only for a chip read.
  logic [15:0] mem [0:255];
  wire         model_oe = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq = model_oe ? mem[sram_addr[7:0]] : 16'hzzzz;

  always @(posedge Clk) begin
    if (!Reset) begin
      mem[8'h12] <= 16'hBEEF;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until memReady[port] is seen; -1 if it never arrives.
  task automatic wait_ready(input int port, output int cycles);
    cycles = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus.memReady[port]) begin
        cycles = t;
        break;
      end
    end
  endtask

  task automatic set_req(input int p, input logic wr, input logic [19:0] a, input logic [15:0] d);
    bus.CE[p] = 1'b0;
    bus.OE[p] = wr;
    bus.WE[p] = ~wr;
    bus.UB[p] = 1'b0;
    bus.LB[p] = 1'b0;
    bus.ADDR[p*20 +: 20]         = a;
    bus.Data_to_SRAM[p*16 +: 16] = d;
  endtask

  task automatic drop_req(input int p);
    bus.CE[p] = 1'b1;
    bus.OE[p] = 1'b1;
    bus.WE[p] = 1'b1;
  endtask

  int          lat;
  int          n;
  int          extra;
  int          idx;
  int          order [4];
  int          holdoff [4];
  logic [15:0] exp_data [4];

  initial begin
    Reset = 1'b0;
    bus.CE = 4'hF; bus.OE = 4'hF; bus.WE = 4'hF; bus.UB = 4'hF; bus.LB = 4'hF;
    bus.ADDR = '0; bus.Data_to_SRAM = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_memReady", 32'(bus.memReady), 0);
    chk("rst_rdata", 32'(bus.Data_from_SRAM), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_dq_oe", 32'(dut.w_dq_oe), 0);
    Reset = 1'b1;
    tick();

    // Single read, port 0
    set_req(0, 1'b0, 20'h00012, 16'h0);
    tick();
    chk("rd_acc0_busy", 32'(busy), 1);
    chk("rd_acc0_oe_ce", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b001);
    chk("rd_acc0_addr", 32'(sram_addr), 32'h12);
    chk("rd_acc0_dq_oe", 32'(dut.w_dq_oe), 0);
    tick();
    chk("rd_acc1_oe", 32'(sram_oe_n), 0);
    chk("rd_acc1_ready", 32'(bus.memReady), 0);
    tick();
    chk("rd_done_ready", 32'(bus.memReady), 4'b0001);
    chk("rd_done_data", 32'(bus.Data_from_SRAM), 32'hBEEF);
    chk("rd_done_oe", 32'(sram_oe_n), 1);
    drop_req(0);
    tick();
    chk("rd_rel_ready", 32'(bus.memReady), 0);
    tick();
    chk("rd_idle_busy", 32'(busy), 0);

    // Write 0x1234 to 0x40 on port 1
    set_req(1, 1'b1, 20'h00040, 16'h1234);
    tick();
    chk("wr_acc0_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b010);
    chk("wr_acc0_dq", 32'(sram_dq), 32'h1234);
    chk("wr_acc0_grant", 32'(grant_id), 1);
    tick();
    chk("wr_acc1_we_hold", 32'(sram_we_n), 1);
    chk("wr_acc1_dq", 32'(sram_dq), 32'h1234);
    tick();
    chk("wr_done_ready", 32'(bus.memReady), 4'b0010);
    chk("wr_done_dq_oe", 32'(dut.w_dq_oe), 0);
    chk("wr_keeps_rdata", 32'(bus.Data_from_SRAM), 32'hBEEF);
    drop_req(1);
    repeat (2) tick();

    // Readback on port 1
    set_req(1, 1'b0, 20'h00040, 16'h0);
    wait_ready(1, lat);
    chk("rb_latency", 32'(lat), 3);
    chk("rb_data", 32'(bus.Data_from_SRAM), 32'h1234);
    drop_req(1);
    repeat (2) tick();

    // Held request on port 3: one pulse only, busy until CE rises
    set_req(3, 1'b0, 20'h00012, 16'h0);
    wait_ready(3, lat);
    chk("held_latency", 32'(lat), 3);
    extra = 0;
    repeat (5) begin
      tick();
      if (bus.memReady[3]) extra++;
    end
    chk("held_extra_pulses", 32'(extra), 0);
    chk("held_busy", 32'(busy), 1);
    drop_req(3);
    tick();
    chk("held_busy_drop", 32'(busy), 0);

    // Contention: all four ports at once
    exp_data[0] = 16'hBEEF; exp_data[1] = 16'h1234;
    exp_data[2] = 16'hBEEF; exp_data[3] = 16'h1234;
    set_req(0, 1'b0, 20'h00012, 16'h0);
    set_req(1, 1'b0, 20'h00040, 16'h0);
    set_req(2, 1'b0, 20'h00012, 16'h0);
    set_req(3, 1'b0, 20'h00040, 16'h0);
    n = 0;
    for (int t = 0; t < 60 && n < 4; t++) begin
      tick();
      if (bus.memReady != 4'b0) begin
        chk("cont_onehot", 32'($onehot(bus.memReady)), 1);
        idx = 0;
        for (int p = 0; p < 4; p++) if (bus.memReady[p]) idx = p;
        chk("cont_grant_id", 32'(grant_id), 32'(idx));
        chk("cont_data", 32'(bus.Data_from_SRAM), 32'(exp_data[idx]));
        order[n] = idx;
        n++;
        drop_req(idx);
      end
    end
    chk("cont_count", 32'(n), 4);
    for (int i = 0; i < 4; i++) chk("cont_order", 32'(order[i]), 32'(i));
    repeat (2) tick();

    // Fairness: port 0 re-requests continuously while port 2 waits
    set_req(0, 1'b0, 20'h00012, 16'h0);
    set_req(2, 1'b0, 20'h00012, 16'h0);
    for (int p = 0; p < 4; p++) holdoff[p] = 0;
    n = 0;
    for (int t = 0; t < 80 && n < 4; t++) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        if (holdoff[p] > 0) begin
          holdoff[p]--;
          if (holdoff[p] == 0) set_req(p, 1'b0, 20'h00012, 16'h0);
        end
      end
      if (bus.memReady != 4'b0) begin
        idx = 0;
        for (int p = 0; p < 4; p++) if (bus.memReady[p]) idx = p;
        order[n] = idx;
        n++;
        drop_req(idx);
        holdoff[idx] = 2;
      end
    end
    chk("fair_count", 32'(n), 4);
    chk("fair_order0", 32'(order[0]), 0);
    chk("fair_order1", 32'(order[1]), 2);
    chk("fair_order2", 32'(order[2]), 0);
    chk("fair_order3", 32'(order[3]), 2);
    drop_req(0);
    drop_req(2);
    repeat (3) tick();
    chk("fair_idle_busy", 32'(busy), 0);

    // Reset asserted during write ACCESS cycle 0
    set_req(1, 1'b1, 20'h00080, 16'h5555);
    tick();
    chk("rstw_pre_we", 32'(sram_we_n), 0);
    Reset = 1'b0;
    #1;
    chk("rstw_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
    chk("rstw_dq_oe", 32'(dut.w_dq_oe), 0);
    chk("rstw_memReady", 32'(bus.memReady), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_rdata", 32'(bus.Data_from_SRAM), 0);
    drop_req(1);
    tick();
    Reset = 1'b1;
    tick();

    // Clean read after reset release
    set_req(0, 1'b0, 20'h00012, 16'h0);
    wait_ready(0, lat);
    chk("post_rst_latency", 32'(lat), 3);
    chk("post_rst_data", 32'(bus.Data_from_SRAM), 32'hBEEF);
    chk("post_rst_grant", 32'(grant_id), 0);
    drop_req(0);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
